// File: rtl/line_seq_pkg.sv
// Shared types for the DrawLine command sequencer.
package line_seq_pkg;

  localparam int LS_COORD_W = 16;
  localparam int LS_COLOR_W = 16;

  // Sequencer states, in the order a line walks through them.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    EMIT,
    ADVANCE,
    SETTLE,
    DONE
  } line_seq_state_t;

  // One line-draw command as it arrives from the decoder.
  typedef struct packed {
    logic [LS_COORD_W-1:0] x1;
    logic [LS_COORD_W-1:0] y1;
    logic [LS_COORD_W-1:0] x2;
    logic [LS_COORD_W-1:0] y2;
    logic [LS_COLOR_W-1:0] color;
  } line_cmd_t;

endpackage

// File: rtl/line_cmd_slot.sv
// Single-entry valid/ready holding register. Accepts a word whenever it is
// empty and releases it when the consumer pulses drain.
module line_cmd_slot #(
  parameter int W = 80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         drain,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic load;

  assign ready = !valid;
  assign load  = in_valid && !valid;

  // Occupancy flag: drain empties the slot, a handshake fills it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload capture on the accepting edge only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (load) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/line_sequencer.sv
// Command-level controller for the DrawLine rasteriser: buffers one command,
// starts DrawLine, pulls pixels, clips them to the framebuffer and offers the
// survivors to the pixel writer.
module line_sequencer
  import line_seq_pkg::*;
#(
  parameter int COORD_W      = LS_COORD_W,
  parameter int COLOR_W      = LS_COLOR_W,
  parameter int FB_W         = 640,
  parameter int FB_H         = 480,
  parameter int SETUP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COORD_W-1:0] cmd_x2,
  input  logic [COORD_W-1:0] cmd_y2,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               le_calculate,
  output logic [COORD_W-1:0] le_x1,
  output logic [COORD_W-1:0] le_y1,
  output logic [COORD_W-1:0] le_x2,
  output logic [COORD_W-1:0] le_y2,
  output logic               le_get_pixel,
  input  logic [COORD_W-1:0] le_x,
  input  logic [COORD_W-1:0] le_y,
  input  logic               le_complete,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               busy,
  output logic [15:0]        lines_done
);

  localparam int CMD_W = 4 * COORD_W + COLOR_W;
  localparam int CNT_W = (SETUP_CYCLES < 2) ? 1 : $clog2(SETUP_CYCLES);
  localparam logic [CNT_W-1:0]   SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [COORD_W-1:0] FB_W_LIM   = COORD_W'(FB_W);
  localparam logic [COORD_W-1:0] FB_H_LIM   = COORD_W'(FB_H);

  line_seq_state_t   state;
  line_seq_state_t   state_nx;
  logic [CNT_W-1:0]  setup_cnt;
  logic              pend_v;
  logic [CMD_W-1:0]  pend_data;
  logic              drain;
  logic              in_bounds;
  logic [COLOR_W-1:0] act_color;

  // The pending slot drains only from IDLE; cmd_ready is low then, so a
  // fill and a drain can never coincide.
  assign drain = (state == IDLE) && pend_v;

  line_cmd_slot #(
    .W(CMD_W)
  ) u_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (cmd_valid),
    .in_data  ({cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color}),
    .drain    (drain),
    .ready    (cmd_ready),
    .valid    (pend_v),
    .data     (pend_data)
  );

  // Unsigned compare: wrapped negative coordinates land far out and clip.
  assign in_bounds = (le_x < FB_W_LIM) && (le_y < FB_H_LIM);

  // Pixel coordinates are only meaningful in EMIT; zero elsewhere.
  assign px_x     = (state == EMIT) ? le_x : '0;
  assign px_y     = (state == EMIT) ? le_y : '0;
  assign px_color = act_color;
  assign busy     = (state != IDLE) || pend_v;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nx     = state;
    le_calculate = 1'b0;
    le_get_pixel = 1'b0;
    px_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (pend_v) state_nx = LOAD;
      end
      LOAD: begin
        le_calculate = 1'b1;
        state_nx     = SETUP;
      end
      SETUP: begin
        if (setup_cnt == '0) state_nx = EMIT;
      end
      EMIT: begin
        px_valid = in_bounds;
        if (!in_bounds || px_ready) begin
          state_nx = le_complete ? DONE : ADVANCE;
        end
      end
      ADVANCE: begin
        le_get_pixel = 1'b1;
        state_nx     = SETTLE;
      end
      SETTLE: begin
        state_nx = EMIT;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // DrawLine setup wait: loaded in LOAD, terminal count at zero in SETUP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      setup_cnt <= '0;
    end else if (state == LOAD) begin
      setup_cnt <= SETUP_LOAD;
    end else if ((state == SETUP) && (setup_cnt != '0)) begin
      setup_cnt <= setup_cnt - 1'b1;
    end
  end

  // Active line registers, copied from the pending slot as it drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      le_x1     <= '0;
      le_y1     <= '0;
      le_x2     <= '0;
      le_y2     <= '0;
      act_color <= '0;
    end else if (drain) begin
      {le_x1, le_y1, le_x2, le_y2, act_color} <= pend_data;
    end
  end

  // Completed-line counter, free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lines_done <= '0;
    end else if (state == DONE) begin
      lines_done <= lines_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_line_sequencer.sv
// Randomised and directed bench for line_sequencer, paired with a
// behavioural DrawLine and a pixel scoreboard.
module tb_line_sequencer;

  localparam int FB_W  = 640;
  localparam int FB_H  = 480;
  localparam int SETUP = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color;
  logic        le_calculate;
  logic [15:0] le_x1, le_y1, le_x2, le_y2;
  logic        le_get_pixel;
  logic [15:0] le_x, le_y;
  logic        le_complete;
  logic        px_valid;
  logic        px_ready;
  logic [15:0] px_x, px_y, px_color;
  logic        busy;
  logic [15:0] lines_done;

  line_sequencer #(
    .COORD_W(16), .COLOR_W(16), .FB_W(FB_W), .FB_H(FB_H), .SETUP_CYCLES(SETUP)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
    .cmd_color(cmd_color),
    .le_calculate(le_calculate),
    .le_x1(le_x1), .le_y1(le_y1), .le_x2(le_x2), .le_y2(le_y2),
    .le_get_pixel(le_get_pixel),
    .le_x(le_x), .le_y(le_y), .le_complete(le_complete),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .busy(busy), .lines_done(lines_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_pass, n_writes, cyc, exp_lines;
  int acc_edge, calc_lbl, done_lbl, pv_lbl;
  bit arm_pv, rand_ready, ready_force;
  logic [47:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  // Line geometry: number of pixels and the k-th pixel of a Bresenham walk.
  function automatic int line_len(int x1, int y1, int x2, int y2);
    int ax, ay;
    ax = (x2 > x1) ? x2 - x1 : x1 - x2;
    ay = (y2 > y1) ? y2 - y1 : y1 - y2;
    return ((ax > ay) ? ax : ay) + 1;
  endfunction

  function automatic logic [31:0] pixel_at(int x1, int y1, int x2, int y2, int k);
    int x, y, dx, dy, sx, sy, err, e2;
    x = x1; y = y1;
    dx = (x2 > x1) ? x2 - x1 : x1 - x2;
    dy = -((y2 > y1) ? y2 - y1 : y1 - y2);
    sx = (x1 < x2) ? 1 : -1;
    sy = (y1 < y2) ? 1 : -1;
    err = dx + dy;
    for (int i = 0; i < k; i++) begin
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return {x[15:0], y[15:0]};
  endfunction

  // Behavioural DrawLine: latches endpoints on calculate, steps on get_pixel.
  logic [15:0] dl_x1, dl_y1, dl_x2, dl_y2;
  int          dl_idx;
  logic [31:0] dl_pix;
  int          dl_len;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_x1 <= '0; dl_y1 <= '0; dl_x2 <= '0; dl_y2 <= '0;
      dl_idx <= 0;
    end else if (le_calculate) begin
      dl_x1 <= le_x1; dl_y1 <= le_y1; dl_x2 <= le_x2; dl_y2 <= le_y2;
      dl_idx <= 0;
    end else if (le_get_pixel && (dl_idx < dl_len - 1)) begin
      dl_idx <= dl_idx + 1;
    end
  end

  always_comb begin
    dl_len = line_len(int'(dl_x1), int'(dl_y1), int'(dl_x2), int'(dl_y2));
    dl_pix = pixel_at(int'(dl_x1), int'(dl_y1), int'(dl_x2), int'(dl_y2), dl_idx);
  end

  assign le_x        = dl_pix[31:16];
  assign le_y        = dl_pix[15:0];
  assign le_complete = (dl_idx == dl_len - 1);

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      px_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Output monitor: scoreboard writes, stall stability, event timestamps.
  initial begin
    logic        prev_stall;
    logic [47:0] prev_px;
    logic [15:0] last_ld;
    prev_stall = 1'b0; prev_px = '0; last_ld = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (px_valid && px_ready) begin
          n_writes++;
          chk("px_expected_avail", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) chk("px_write", 64'({px_x, px_y, px_color}), 64'(exp_q.pop_front()));
        end
        if (px_valid) chk("no_adv_while_valid", 64'(le_get_pixel), 64'(0));
        if (prev_stall) chk("stall_hold", 64'({px_valid, px_x, px_y, px_color}), 64'({1'b1, prev_px}));
        prev_stall = px_valid && !px_ready;
        prev_px    = {px_x, px_y, px_color};
        if (lines_done != last_ld) done_lbl = cyc;
        last_ld = lines_done;
        if (le_calculate) calc_lbl = cyc + 1;
        if (arm_pv && px_valid) begin
          pv_lbl = cyc + 1;
          arm_pv = 1'b0;
        end
      end else begin
        prev_stall = 1'b0;
        last_ld    = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] x1, input logic [15:0] y1,
                      input logic [15:0] x2, input logic [15:0] y2,
                      input logic [15:0] col);
    int budget;
    int n;
    logic [31:0] p;
    @(negedge clk);
    cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2; cmd_color = col;
    cmd_valid = 1'b1;
    budget = 0;
    while (!cmd_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_edge  = cyc;
    cmd_valid = 1'b0;
    exp_lines++;
    n = line_len(int'(x1), int'(y1), int'(x2), int'(y2));
    for (int i = 0; i < n; i++) begin
      p = pixel_at(int'(x1), int'(y1), int'(x2), int'(y2), i);
      if (int'(p[31:16]) < FB_W && int'(p[15:0]) < FB_H) exp_q.push_back({p, col});
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_pending_px", 64'(exp_q.size()), 64'(0));
    chk("lines_done", 64'(lines_done), 64'(exp_lines[15:0]));
  endtask

  task automatic wait_px_valid(input string tag);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!px_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk(tag, 64'(px_valid), 64'(1));
  endtask

  initial begin
    int wr0, bad, budget;
    int x1, y1, x2, y2, cat;
    n_chk = 0; n_pass = 0; n_writes = 0; exp_lines = 0;
    rand_ready = 1'b0; ready_force = 1'b1; arm_pv = 1'b0;
    reset = 1'b0; cmd_valid = 1'b0;
    cmd_x1 = '0; cmd_y1 = '0; cmd_x2 = '0; cmd_y2 = '0; cmd_color = '0;

    #3;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_px_valid", 64'(px_valid), 64'(0));
    chk("rst_calc", 64'(le_calculate), 64'(0));
    chk("rst_get_pixel", 64'(le_get_pixel), 64'(0));
    chk("rst_lines_done", 64'(lines_done), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Horizontal line with free-flowing writer, plus latency checks.
    wr0 = n_writes; arm_pv = 1'b1;
    send(16'd10, 16'd50, 16'd20, 16'd50, 16'hF800);
    wait_idle();
    chk("hline_writes", 64'(n_writes - wr0), 64'(11));
    chk("hline_calc_lat", 64'(calc_lbl - acc_edge), 64'(2));
    chk("hline_first_px_lat", 64'(pv_lbl - acc_edge), 64'(3 + SETUP));

    // Same line, writer stalls 5 cycles on the third pixel.
    wr0 = n_writes;
    send(16'd10, 16'd50, 16'd20, 16'd50, 16'hF800);
    budget = 0;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (n_writes != wr0 + 2 && budget < 200);
    ready_force = 1'b0;
    wait_px_valid("bp_third_px_valid");
    for (int s = 0; s < 5; s++) begin
      if (s != 0) @(negedge clk);
      chk("bp_stall_valid", 64'(px_valid), 64'(1));
      chk("bp_stall_x", 64'(px_x), 64'(12));
      chk("bp_stall_no_adv", 64'(le_get_pixel), 64'(0));
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    wait_idle();
    chk("bp_writes", 64'(n_writes - wr0), 64'(11));

    // Degenerate point line.
    wr0 = n_writes;
    send(16'd10, 16'd5, 16'd10, 16'd5, 16'h1234);
    wait_idle();
    chk("point_writes", 64'(n_writes - wr0), 64'(1));

    // Line straddling the right edge: 10 kept, 11 clipped.
    wr0 = n_writes;
    send(16'd630, 16'd10, 16'd650, 16'd10, 16'hABCD);
    wait_idle();
    chk("clip_writes", 64'(n_writes - wr0), 64'(10));

    // Second command arrives while the first is emitting.
    wr0 = n_writes;
    send(16'd0, 16'd0, 16'd5, 16'd3, 16'h07E0);
    wait_px_valid("b2b_first_emit");
    send(16'd10, 16'd20, 16'd14, 16'd20, 16'h001F);
    bad = 0; budget = 0;
    @(negedge clk);
    while (!le_calculate && budget < 300) begin
      if (cmd_ready) bad = 1;
      @(negedge clk);
      budget++;
    end
    chk("b2b_second_calc", 64'(le_calculate), 64'(1));
    chk("b2b_ready_low", 64'(bad), 64'(0));
    chk("b2b_calc_after_done", 64'((cyc + 1) - done_lbl), 64'(2));
    wait_idle();
    chk("b2b_writes", 64'(n_writes - wr0), 64'(11));

    // Reset in the middle of a line with a second command pending.
    send(16'd100, 16'd100, 16'd130, 16'd100, 16'h5555);
    wait_px_valid("rst_mid_emit1");
    send(16'd200, 16'd200, 16'd210, 16'd205, 16'hAAAA);
    wait_px_valid("rst_mid_emit2");
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_px_valid", 64'(px_valid), 64'(0));
    chk("mid_rst_calc", 64'(le_calculate), 64'(0));
    chk("mid_rst_get_pixel", 64'(le_get_pixel), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_lines_done", 64'(lines_done), 64'(0));
    exp_q.delete();
    exp_lines = 0;
    wr0 = n_writes;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_writes", 64'(n_writes - wr0), 64'(0));

    // Randomised lines near the clip borders under random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0: begin x1 = $urandom_range(620, 660);     y1 = $urandom_range(0, 479);   end
        1: begin x1 = $urandom_range(0, 639);       y1 = $urandom_range(470, 490); end
        2: begin x1 = $urandom_range(65500, 65520); y1 = $urandom_range(0, 100);   end
        default: begin x1 = $urandom_range(6, 630); y1 = $urandom_range(6, 470);   end
      endcase
      x2 = x1 + $urandom_range(0, 12) - 6;
      y2 = y1 + $urandom_range(0, 12) - 6;
      if (x2 < 0) x2 = 0;
      if (y2 < 0) y2 = 0;
      send(16'(x1), 16'(y1), 16'(x2), 16'(y2), 16'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle();
      else repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    wait_idle();
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
